multicycle_datapath: RTL and testbench

Datapath half of the multicycle MIPS processor; the consumer of every control signal the control unit drives, and the producer of the opcode and zero feedback it samples. Holds PC, IR, MDR, A, B, ALUOut, the register file, a unified instruction/data memory and the ALU. Sits beside the control unit under the processor top; both share clk and rst.

---
 rtl/multicycle_datapath.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Datapath of the multicycle MIPS core: PC/IR/MDR/A/B/ALUOut, register file, unified memory and ALU.
// Optional feature macro: DP_OVF_TRAP_EN (sticky signed-overflow flag with writeback suppression).
module multicycle_datapath #(
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 64,
    parameter int RF_DEPTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         regdst,
    input  logic                         memtoreg,
    input  logic                         memread,
    input  logic                         memwrite,
    input  logic                         IRWrite,
    input  logic                         IorD,
    input  logic                         PCEn,
    input  logic                         regwrite,
    input  logic [1:0]                   aluop,
    input  logic [1:0]                   alusrcA,
    input  logic [1:0]                   alusrcB,
    input  logic [1:0]                   PCsrc,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [DATA_W-1:0]            ld_data,
    output logic [5:0]                   opcode,
    output logic                         zero,
    output logic [DATA_W-1:0]            pc,
    output logic                         ovf
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_NONE
    } alu_fn_e;

    logic [DATA_W-1:0]               mem [MEM_WORDS];
    logic [RF_DEPTH-1:0][DATA_W-1:0] rf;

    logic [DATA_W-1:0]        ir;
    logic [DATA_W-1:0]        mdr;
    logic [DATA_W-1:0]        reg_a;
    logic [DATA_W-1:0]        reg_b;
    logic [DATA_W-1:0]        alu_out;

    logic [AW-1:0]            mem_idx;
    logic [DATA_W-1:0]        mem_rd;
    logic [4:0]               wr_sel;
    logic [DATA_W-1:0]        wr_data;
    logic                     rf_we;
    logic [DATA_W-1:0]        imm_ext;
    logic [DATA_W-1:0]        imm_sh;
    logic [DATA_W-1:0]        jump_tgt;
    logic [DATA_W-1:0]        next_pc;
    logic signed [DATA_W-1:0] src_a;
    logic signed [DATA_W-1:0] src_b;
    logic signed [DATA_W-1:0] alu_result;
    alu_fn_e                  alu_fn;

    assign opcode   = ir[31:26];
    assign imm_ext  = {{(DATA_W-16){ir[15]}}, ir[15:0]};
    assign imm_sh   = {imm_ext[DATA_W-3:0], 2'b00};
    assign jump_tgt = {pc[DATA_W-1:28], ir[25:0], 2'b00};

    // Word addressing: byte-address bits above the memory size are dropped, so addresses wrap.
    assign mem_idx = IorD ? alu_out[AW+1:2] : pc[AW+1:2];
    assign mem_rd  = mem[mem_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (ld_en) begin
                mem[ld_addr] <= ld_data;
            end
        end else if (memwrite) begin
            mem[mem_idx] <= reg_b;
        end
    end

    always_comb begin
        src_a = '0;
        case (alusrcA)
            2'b00:   src_a = pc;
            2'b01:   src_a = reg_a;
            default: src_a = '0;
        endcase
    end

    always_comb begin
        src_b = '0;
        case (alusrcB)
            2'b00:   src_b = reg_b;
            2'b01:   src_b = DATA_W'(4);
            2'b10:   src_b = imm_ext;
            default: src_b = imm_sh;
        endcase
    end

    always_comb begin
        alu_fn = ALU_ADD;
        case (aluop)
            2'b01: alu_fn = ALU_SUB;
            2'b10: begin
                case (ir[5:0])
                    6'b100000: alu_fn = ALU_ADD;
                    6'b100010: alu_fn = ALU_SUB;
                    6'b100100: alu_fn = ALU_AND;
                    6'b100101: alu_fn = ALU_OR;
                    6'b101010: alu_fn = ALU_SLT;
                    default:   alu_fn = ALU_NONE;
                endcase
            end
            default: alu_fn = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_fn)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    always_comb begin
        next_pc = pc;
        case (PCsrc)
            2'b00:   next_pc = alu_result;
            2'b01:   next_pc = alu_out;
            2'b10:   next_pc = jump_tgt;
            default: next_pc = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= '0;
            ir      <= '0;
            mdr     <= '0;
            reg_a   <= '0;
            reg_b   <= '0;
            alu_out <= '0;
        end else begin
            if (PCEn) begin
                pc <= next_pc;
            end
            if (IRWrite) begin
                ir <= mem_rd;
            end
            if (memread) begin
                mdr <= mem_rd;
            end
            reg_a   <= rf[ir[25:21]];
            reg_b   <= rf[ir[20:16]];
            alu_out <= alu_result;
        end
    end

    assign wr_sel  = regdst ? ir[15:11] : ir[20:16];
    assign wr_data = memtoreg ? mdr : alu_out;

`ifdef DP_OVF_TRAP_EN
    function automatic logic signed_ovf(input logic signed [DATA_W-1:0] x,
                                        input logic signed [DATA_W-1:0] y,
                                        input logic signed [DATA_W-1:0] r,
                                        input logic                     sub);
        logic y_sign;
        y_sign = sub ? ~y[DATA_W-1] : y[DATA_W-1];
        return (x[DATA_W-1] == y_sign) && (r[DATA_W-1] != x[DATA_W-1]);
    endfunction

    logic ovf_now;
    logic ovf_last;

    assign ovf_now = (aluop == 2'b10) &&
                     (((alu_fn == ALU_ADD) && signed_ovf(src_a, src_b, alu_result, 1'b0)) ||
                      ((alu_fn == ALU_SUB) && signed_ovf(src_a, src_b, alu_result, 1'b1)));

    // ovf_last marks that the value now held in ALUOut overflowed, so its writeback is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf      <= 1'b0;
            ovf_last <= 1'b0;
        end else begin
            ovf      <= ovf | ovf_now;
            ovf_last <= ovf_now;
        end
    end

    assign rf_we = regwrite && !(ovf_last && !memtoreg);
`else
    assign ovf   = 1'b0;
    assign rf_we = regwrite;
`endif

    // $0 is never written, so it always reads back as zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf <= '0;
        end else if (rf_we && (wr_sel != 5'd0)) begin
            rf[wr_sel] <= wr_data;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: acts as the control unit and compares against an instruction-level model.
module tb_multicycle_datapath;
    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        regdst, memtoreg, memread, memwrite, IRWrite, IorD, PCEn, regwrite;
    logic [1:0]  aluop, alusrcA, alusrcB, PCsrc;
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;
    logic [5:0]  opcode;
    logic        zero;
    logic [31:0] pc;
    logic        ovf;

    always #5 clk = ~clk;

    multicycle_datapath #(.DATA_W(32), .MEM_WORDS(MEM_WORDS), .RF_DEPTH(32)) dut (
        .clk(clk), .rst(rst),
        .regdst(regdst), .memtoreg(memtoreg), .memread(memread), .memwrite(memwrite),
        .IRWrite(IRWrite), .IorD(IorD), .PCEn(PCEn), .regwrite(regwrite),
        .aluop(aluop), .alusrcA(alusrcA), .alusrcB(alusrcB), .PCsrc(PCsrc),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .opcode(opcode), .zero(zero), .pc(pc), .ovf(ovf)
    );

    int errors = 0;
    int checks = 0;

    // Architectural reference state
    logic [31:0] m_mem [MEM_WORDS];
    logic [31:0] m_rf  [32];
    logic [31:0] m_pc;
    logic        m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        regdst = 0; memtoreg = 0; memread = 0; memwrite = 0;
        IRWrite = 0; IorD = 0; PCEn = 0; regwrite = 0;
        aluop = 2'b00; alusrcA = 2'b00; alusrcB = 2'b00; PCsrc = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_pc  = 32'd0;
        m_ovf = 1'b0;
    endtask

    function automatic logic [31:0] ref_alu(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b, output logic of);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        of = 1'b0;
        case (f)
            6'h20: begin s = sa + sb; of = (s > 64'sd2147483647) || (s < -64'sd2147483648); return s[31:0]; end
            6'h22: begin s = sa - sb; of = (s > 64'sd2147483647) || (s < -64'sd2147483648); return s[31:0]; end
            6'h24: return a & b;
            6'h25: return a | b;
            6'h2a: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] probe_instr(input logic [4:0] rs, input int ret_addr);
        return {6'h3f, rs, 5'd0, 16'(ret_addr)};
    endfunction

    function automatic logic [31:0] gen_instr(input int w);
        logic [4:0] rs, rt, rd;
        logic [5:0] fn;
        int         kind, off, word, span;
        kind = int'($urandom_range(0, 9));
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        span = (44 - (w + 1)) < 2 ? (44 - (w + 1)) : 2;
        case (kind)
            0, 1, 2, 3: begin
                case ($urandom_range(0, 5))
                    0: fn = 6'h20;
                    1: fn = 6'h22;
                    2: fn = 6'h24;
                    3: fn = 6'h25;
                    4: fn = 6'h2a;
                    default: fn = 6'h27;
                endcase
                return {6'h00, rs, rt, rd, 5'd0, fn};
            end
            4, 5: begin
                word = int'($urandom_range(48, 63));
                off  = word * 4 + 256 * int'($urandom_range(0, 2));
                return {6'h23, 5'd0, 5'($urandom_range(1, 7)), 16'(off)};
            end
            6: begin
                word = int'($urandom_range(49, 63));
                off  = word * 4 + 256 * int'($urandom_range(0, 2));
                return {6'h2b, 5'd0, rt, 16'(off)};
            end
            7: begin
                if ($urandom_range(0, 1) == 1) rt = rs;
                off = int'($urandom_range(0, 2));
                if (off > span) off = span;
                return {6'h04, rs, rt, 16'(off)};
            end
            8: return probe_instr(rs, (w + 1) * 4);
            default: begin
                off = int'($urandom_range(0, 2));
                if (off > span) off = span;
                return {6'h02, 26'(w + 1 + off)};
            end
        endcase
    endfunction

    task automatic fetch(output logic [31:0] w);
        w = m_mem[m_pc[7:2]];
        idle(); IRWrite = 1; alusrcA = 2'b00; alusrcB = 2'b01; PCsrc = 2'b00; PCEn = 1;
        tick();
        m_pc = m_pc + 32'd4;
        check("fetch_opcode", {26'd0, opcode}, {26'd0, w[31:26]});
    endtask

    task automatic run_instr();
        logic [31:0] ir, a, b, r, imm, addr;
        logic [4:0]  rs, rt, rd;
        logic        of, suppress;
        fetch(ir);
        rs  = ir[25:21];
        rt  = ir[20:16];
        rd  = ir[15:11];
        imm = {{16{ir[15]}}, ir[15:0]};
        a   = m_rf[rs];
        b   = m_rf[rt];
        idle(); alusrcA = 2'b00; alusrcB = 2'b11; tick();
        case (ir[31:26])
            6'h00: begin
                idle(); alusrcA = 2'b01; alusrcB = 2'b00; aluop = 2'b10;
                #1;
                r = ref_alu(ir[5:0], a, b, of);
                check("zero_rtype", {31'd0, zero}, {31'd0, (r == 32'd0)});
                tick();
                idle(); regdst = 1; regwrite = 1; tick();
                suppress = 1'b0;
`ifdef DP_OVF_TRAP_EN
                if (of) m_ovf = 1'b1;
                suppress = of;
`endif
                if (!suppress && rd != 5'd0) m_rf[rd] = r;
            end
            6'h23, 6'h2b: begin
                addr = a + imm;
                idle(); alusrcA = 2'b01; alusrcB = 2'b10; tick();
                if (ir[31:26] == 6'h23) begin
                    idle(); IorD = 1; memread = 1; tick();
                    idle(); memtoreg = 1; regwrite = 1; tick();
                    if (rt != 5'd0) m_rf[rt] = m_mem[addr[7:2]];
                end else begin
                    idle(); IorD = 1; memwrite = 1; tick();
                    m_mem[addr[7:2]] = b;
                end
            end
            6'h04: begin
                idle(); alusrcA = 2'b01; alusrcB = 2'b00; aluop = 2'b01; PCsrc = 2'b01;
                #1;
                check("zero_beq", {31'd0, zero}, {31'd0, (a == b)});
                PCEn = zero;
                tick();
                if (a == b) m_pc = m_pc + (imm << 2);
            end
            6'h02: begin
                idle(); PCsrc = 2'b10; PCEn = 1; tick();
                m_pc = {m_pc[31:28], ir[25:0], 2'b00};
            end
            default: begin
                idle(); alusrcA = 2'b01; alusrcB = 2'b00; PCsrc = 2'b00; PCEn = 1; tick();
                check($sformatf("probe_r%0d", rs), pc, a);
                idle(); alusrcA = 2'b10; alusrcB = 2'b10; PCsrc = 2'b00; PCEn = 1; tick();
                m_pc = imm;
            end
        endcase
        check("pc", pc, m_pc);
        check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    endtask

    initial begin
        logic [31:0] w;
        int          n;

        for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = $urandom();
        m_mem[0]  = 32'h8C010010;
        m_mem[1]  = probe_instr(5'd5, 8);
        m_mem[2]  = 32'h8C020014;
        m_mem[3]  = 32'h08000010;
        m_mem[4]  = 32'h0000BEEF;
        m_mem[5]  = 32'h7FFFFFFF;
        m_mem[6]  = 32'h00000001;
        m_mem[16] = 32'h8C030018;
        m_mem[17] = 32'h00432020;
        m_mem[18] = probe_instr(5'd4, 76);
        m_mem[19] = probe_instr(5'd1, 80);
        for (int i = 20; i < 44; i++) m_mem[i] = gen_instr(i);
        m_mem[44] = {6'h23, 5'd0, 5'd5, 16'd192};
        m_mem[45] = {6'h2b, 5'd0, 5'd5, 16'd264};
        m_mem[46] = {6'h2b, 5'd0, 5'd5, 16'd268};
        m_mem[48] = 32'hA5A5A5A5;
        model_reset();

        rst = 0; ld_en = 0; ld_addr = '0; ld_data = '0;
        idle();
        for (int i = 0; i < MEM_WORDS; i++) begin
            ld_en = 1; ld_addr = 6'(i); ld_data = m_mem[i];
            tick();
        end
        ld_en = 0;
        tick();
        #1;
        check("rst_pc", pc, 32'd0);
        check("rst_opcode", {26'd0, opcode}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);

        // Preload strobe while out of reset must not touch memory
        rst = 1; ld_en = 1; ld_addr = 6'd3; ld_data = 32'hDEADBEEF;
        tick();
        ld_en = 0;
        check("idle_pc", pc, 32'd0);

        n = 0;
        while (m_pc != 32'd184 && n < 200) begin
            run_instr();
            n++;
        end
        check("pc_at_w46", pc, 32'd184);

        // sw to a wrapped address, aborted by reset on its memory-write edge
        fetch(w);
        idle(); alusrcA = 2'b00; alusrcB = 2'b11; tick();
        idle(); alusrcA = 2'b01; alusrcB = 2'b10; tick();
        idle(); IorD = 1; memwrite = 1; rst = 0; tick();
        model_reset();
        idle();
        #1;
        check("midrst_pc", pc, m_pc);
        check("midrst_opcode", {26'd0, opcode}, 32'd0);
        check("midrst_ovf", {31'd0, ovf}, 32'd0);
        check("midrst_zero", {31'd0, zero}, 32'd1);
        rst = 1;

        run_instr();
        run_instr();
        fetch(w);
        check("mem2_wrap_opcode", {26'd0, opcode}, 32'h29);
        fetch(w);
        check("mem3_kept_opcode", {26'd0, opcode}, 32'h02);
        check("pc_end", pc, m_pc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
